// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared state encoding, width default and parity constants for uart_tx.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_if
// Brief    : Request/serial-line bundle between a byte source and uart_tx.
// Revision : 1.0
// ============================================================================
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_data_valid;
  logic                  i_par_en;
  logic                  i_par_typ;
  logic                  o_tx_out;
  logic                  o_busy;

  modport master (
    output i_data, i_data_valid, i_par_en, i_par_typ,
    input  o_tx_out, o_busy
  );

  modport slave (
    input  i_data, i_data_valid, i_par_en, i_par_typ,
    output o_tx_out, o_busy
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_parity.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_parity
// Brief    : Combinational even/odd parity over the latched payload.
// Revision : 1.0
// ============================================================================
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : UART frame serializer, one bit per i_clk edge, registered outputs.
//            Parity state/logic present only when UART_TX_PARITY_EN is defined.
// Revision : 1.0
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic      i_clk,
  input  logic      i_rst,
  uart_tx_if.slave  bus
);

  localparam int                 CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_nxt, cnt_inc;
  logic [DATA_WIDTH-1:0]   data_q, data_nxt;
  logic                    tx_q, tx_nxt;
  logic                    busy_q, busy_nxt;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_nxt;
  logic par_typ_q, par_typ_nxt;
  logic par_bit;

  uart_tx_parity #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (data_q),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );
`endif

  assign cnt_inc = bit_cnt + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      data_q    <= data_nxt;
      tx_q      <= tx_nxt;
      busy_q    <= busy_nxt;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_nxt;
      par_typ_q <= par_typ_nxt;
`endif
    end
  end

  // Outputs are computed for the state being entered so they register cleanly.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    data_nxt    = data_q;
    tx_nxt      = tx_q;
    busy_nxt    = busy_q;
`ifdef UART_TX_PARITY_EN
    par_en_nxt  = par_en_q;
    par_typ_nxt = par_typ_q;
`endif
    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (bus.i_data_valid) begin
          state_nxt   = START;
          data_nxt    = bus.i_data;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_en_nxt  = bus.i_par_en;
          par_typ_nxt = bus.i_par_typ;
`endif
        end
      end
      START: begin
        state_nxt   = DATA;
        bit_cnt_nxt = '0;
        tx_nxt      = data_q[0];
        busy_nxt    = 1'b1;
      end
      DATA: begin
        busy_nxt = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
          if (par_en_q) begin
            state_nxt = PARITY;
            tx_nxt    = par_bit;
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
`else
          state_nxt = STOP;
          tx_nxt    = 1'b1;
`endif
        end else begin
          bit_cnt_nxt = cnt_inc;
          tx_nxt      = data_q[cnt_inc];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        state_nxt = STOP;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b1;
      end
`endif
      STOP: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = '0;
        tx_nxt      = 1'b1;
        busy_nxt    = 1'b0;
      end
    endcase
  end

  assign bus.o_tx_out = tx_q;
  assign bus.o_busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx against a frame-queue line model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx;
  import uart_pkg::*;

  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_WIDTH(W)) bus ();

  uart_tx #(.DATA_WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic exp_tx   = 1'b1;
  logic exp_busy = 1'b0;
  bit   cap_on   = 1'b0;
  logic cap_tx[$];
  logic cap_busy[$];

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // A whole frame is the line's future: start, payload LSB first, optional parity, stop.
  function automatic void build_frame(input logic [W-1:0] d, input logic with_par, input logic pt);
    exp_q.push_back(1'b0);
    for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
    if (with_par) exp_q.push_back((^d) ^ pt);
    exp_q.push_back(1'b1);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    exp_tx   = 1'b1;
    exp_busy = 1'b0;
  endfunction

  function automatic void model_step();
    if (exp_q.size() > 0) begin
      exp_tx   = exp_q.pop_front();
      exp_busy = 1'b1;
    end else if (!exp_busy && bus.i_data_valid) begin
      build_frame(bus.i_data, PAR_ON && bus.i_par_en, bus.i_par_typ);
      exp_tx   = exp_q.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check("tx_out", bus.o_tx_out, exp_tx);
    check("busy", bus.o_busy, exp_busy);
    if (cap_on) begin
      cap_tx.push_back(bus.o_tx_out);
      cap_busy.push_back(bus.o_busy);
    end
  endtask

  task automatic drive(input logic [W-1:0] d, input logic v, input logic pe, input logic pt);
    bus.i_data       = d;
    bus.i_data_valid = v;
    bus.i_par_en     = pe;
    bus.i_par_typ    = pt;
  endtask

  task automatic cap_start();
    cap_tx.delete();
    cap_busy.delete();
    cap_on = 1'b1;
  endtask

  // seq holds the expected line bits in time order, first bit in the MSB of n bits.
  task automatic check_seq(input string name, input logic [31:0] seq, input int n);
    int bc;
    cap_on = 1'b0;
    check_int({name, "_len"}, (cap_tx.size() > n) ? 1 : 0, 1);
    if (cap_tx.size() > n) begin
      bc = 0;
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s[%0d]", name, i), cap_tx[i], seq[n-1-i]);
        if (cap_busy[i] === 1'b1) bc++;
      end
      check_int({name, "_busy_cycles"}, bc, n);
      check({name, "_idle_tx"}, cap_tx[n], 1'b1);
      check({name, "_idle_busy"}, cap_busy[n], 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] d;
    drive('0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    #3 rst_n = 1'b1;

    // 0xA5 without parity, accepted on the first edge after reset release
    cap_start();
    drive(8'hA5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (11) tick();
    check_seq("a5_frame", 32'b0101001011, 10);

`ifdef UART_TX_PARITY_EN
    cap_start();
    drive(8'h03, 1'b1, 1'b1, PAR_EVEN);
    tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (12) tick();
    check_seq("par_even", 32'b01100000001, 11);

    cap_start();
    drive(8'h03, 1'b1, 1'b1, PAR_ODD);
    tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (12) tick();
    check_seq("par_odd", 32'b01100000011, 11);
`else
    cap_start();
    drive(8'hFF, 1'b1, 1'b1, 1'b1);
    tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (11) tick();
    check_seq("no_par_ff", 32'b0111111111, 10);
`endif

    // valid held high: two frames with a single idle-high cycle between them
    cap_start();
    drive(8'h0F, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'hF0, 1'b1, 1'b0, 1'b0);
    repeat (11) tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (11) tick();
    cap_on = 1'b0;
    check_int("b2b_len", (cap_tx.size() >= 22) ? 1 : 0, 1);
    if (cap_tx.size() >= 22) begin
      for (int i = 0; i < 21; i++)
        check($sformatf("b2b[%0d]", i), cap_tx[i], logic'((21'b011110000110000011111 >> (20 - i)) & 1));
      check("b2b_gap_busy", cap_busy[10], 1'b0);
      check("b2b_second_busy", cap_busy[11], 1'b1);
    end

    // a mid-frame request is dropped and the frame is unchanged
    cap_start();
    drive(8'h3C, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    drive(8'hC3, 1'b1, 1'b1, 1'b1);
    tick();
    drive(8'hC3, 1'b0, 1'b0, 1'b0);
    repeat (7) tick();
    check_seq("midframe", 32'b0001111001, 10);
    check("midframe_dropped", cap_busy[11], 1'b0);

    // asynchronous reset during data bit 3, then a full 0x55 frame
    drive(8'($urandom), 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    check("pre_reset_busy", bus.o_busy, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_tx", bus.o_tx_out, 1'b1);
    check("async_rst_busy", bus.o_busy, 1'b0);
    drive(8'h55, 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    cap_start();
    tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (11) tick();
    check_seq("post_rst_55", 32'b0101010101, 10);

    // randomized traffic checked cycle by cycle against the model
    for (int n = 0; n < 600; n++) begin
      d = 8'($urandom);
      drive(d, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
      tick();
    end
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (14) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of payload bits per frame.
REQ-002 The block SHALL have port i_clk, input, 1, the bit clock (one rising edge per UART bit period, driven by the clock divider output).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset on port i_rst, input, 1.
REQ-004 The block SHALL have port i_data, input, DATA_WIDTH, the payload byte to transmit.
REQ-005 The block SHALL have port i_data_valid, input, 1, a request to send i_data.
REQ-006 The block SHALL have port i_par_en, input, 1, where 1 appends a parity bit.
REQ-007 The block SHALL have port i_par_typ, input, 1, where 0 selects even parity and 1 selects odd parity.
REQ-008 The block SHALL have port o_tx_out, output, 1, the serial line, idle high.
REQ-009 The block SHALL have port o_busy, output, 1, which is high while a frame is in progress.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-011 In IDLE, o_tx_out SHALL be 1 and o_busy SHALL be 0.
REQ-012 In IDLE, i_data_valid=1 at a rising edge SHALL latch i_data, i_par_en and i_par_typ, and SHALL move the FSM to START.
REQ-013 A frame SHALL be unaffected by input changes after acceptance.
REQ-014 START SHALL last 1 cycle, with o_tx_out=0.
REQ-015 DATA SHALL last DATA_WIDTH cycles and SHALL send the latched data LSB first.
REQ-016 The bit counter SHALL count 0..DATA_WIDTH-1 and clear on exit from DATA.
REQ-017 After the last data bit, the FSM SHALL enter PARITY if latched par_en=1, and STOP otherwise.
REQ-018 PARITY SHALL last 1 cycle and SHALL output XOR(data) when latched par_typ=0, and ~XOR(data) when par_typ=1.
REQ-019 STOP SHALL last 1 cycle with o_tx_out=1 and SHALL then return to IDLE.
REQ-020 o_busy SHALL be 1 in START, DATA, PARITY and STOP.
REQ-021 i_data_valid SHALL be ignored while o_busy=1; there is no queuing.
REQ-022 o_tx_out and o_busy SHALL be registered, with no combinational path from any input.
REQ-023 Latency SHALL be: valid sampled at edge k puts the start bit on o_tx_out after edge k.
REQ-024 Frame length SHALL be DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 cycles with parity.
REQ-025 Minimum spacing between frames SHALL be 1 IDLE cycle, since acceptance happens only in IDLE.
REQ-026 If i_data_valid is held high continuously, the block SHALL send back-to-back frames separated by exactly one idle-high cycle.

Reset
REQ-027 Asserting i_rst low SHALL immediately force IDLE, o_tx_out=1, o_busy=0, bit counter=0, and the data/parity latches to 0.
REQ-028 A reset mid-frame SHALL abort the frame with the line high; no partial stop bit is owed.
REQ-029 The first valid acceptance SHALL occur at the first rising edge after i_rst deasserts.

Configuration
REQ-030 The macro UART_TX_PARITY_EN SHALL control parity support.
REQ-031 With UART_TX_PARITY_EN defined, the PARITY state and parity logic SHALL be present, and i_par_en/i_par_typ SHALL behave per REQ-017 and REQ-018.
REQ-032 Without UART_TX_PARITY_EN, the PARITY state and parity logic SHALL be absent, i_par_en/i_par_typ SHALL remain as ports but be ignored, and every frame SHALL be DATA_WIDTH+2 cycles.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state encoding, the DATA_WIDTH default, and parity-type constants (PAR_EVEN=0, PAR_ODD=1).
REQ-034 One sub-module, uart_tx_parity, SHALL compute the parity bit combinationally from the latched data and par_typ, and SHALL be instantiated only under UART_TX_PARITY_EN.

Verification
REQ-035 Reset with i_rst=0 mid-DATA (bit 3) SHALL give o_tx_out=1 and o_busy=0 immediately (asynchronously); after release, valid with 0x55 SHALL send a full, correct frame.
REQ-036 i_data=0xA5, par_en=0, valid pulsed 1 cycle SHALL give o_tx_out sequence 0,1,0,1,0,0,1,0,1,1, with o_busy high for 10 cycles.
REQ-037 i_data=0x03, par_en=1, par_typ=0 (macro defined) SHALL give frame 0,1,1,0,0,0,0,0,0,P=0,1 (11 cycles); par_typ=1 SHALL give P=1.
REQ-038 Valid held high with 0x0F then 0xF0 SHALL produce two frames separated by exactly one idle-high cycle.
REQ-039 Changing i_data and pulsing i_data_valid mid-frame SHALL leave the current frame unchanged, with the new request dropped.
REQ-040 Macro undefined, par_en=1, data 0xFF SHALL give a 10-cycle frame with no parity bit.
